uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
- REQ-001: Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
- REQ-002: Parameter BAUD_RATE, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division).
- REQ-003: Parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame, LSB first.
- REQ-004: Parameter PARITY_MODE, default 0; 0 = none, 1 = odd, 2 = even.
- REQ-005: Parameter STOP_BITS, default 1, legal 1 or 2.
- REQ-006: clk  input  1  system clock; all logic on rising edge.
- REQ-007: rst_n  input  1  asynchronous active-low reset.
- REQ-008: rx  input  1  asynchronous serial line, idle high.
- REQ-009: data_out  output  DATA_BITS  received payload, stable while valid=1.
- REQ-010: valid  output  1  payload available, held until accepted.
- REQ-011: ready  input  1  consumer accepts when valid && ready on a rising edge.
- REQ-012: frame_err  output  1  qualifies data_out: a stop bit was sampled low.
- REQ-013: parity_err  output  1  qualifies data_out: parity check failed.
- REQ-014: overrun  output  1  one-cycle pulse: a completed frame was dropped.

Function
- REQ-015: rx SHALL pass a 2-flop synchronizer (reset to 1); the FSM SHALL use only the synchronized value.
- REQ-016: FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a single bit-timing counter SHALL run in every state except IDLE.
- REQ-017: IDLE -> START on synchronized rx = 0; counter loads 0.
- REQ-018: In START, at count CLKS_PER_BIT/2 - 1: rx = 0 -> DATA with the counter cleared; rx = 1 -> IDLE (glitch rejection, no outputs change).
- REQ-019: In DATA/PARITY/STOP, a sample SHALL be taken when the counter reaches CLKS_PER_BIT - 1, and the counter SHALL then clear, so every sample lands mid-bit.
- REQ-020: DATA SHALL shift DATA_BITS samples LSB first, then go to PARITY if parity is enabled and PARITY_MODE != 0, otherwise to STOP.
- REQ-021: The parity bit SHALL be checked against the XOR of the payload (odd: XOR ^ bit must be 1; even: must be 0).
- REQ-022: STOP SHALL sample STOP_BITS bits; frame_err = 1 if any stop sample is 0.
- REQ-023: On the final stop sample the FSM SHALL return to IDLE.
  - If valid = 0 or ready = 1 in that cycle, data_out, frame_err and parity_err SHALL be loaded and valid SHALL be set on the next edge (1-cycle latency).
- REQ-024: If valid = 1 and ready = 0 at frame completion, the new frame SHALL be discarded, the held data SHALL remain unchanged, and overrun SHALL pulse for 1 cycle.
- REQ-025: valid SHALL clear on the edge where valid && ready, unless a new frame loads in the same cycle, in which case it SHALL stay 1 with the new data.
- REQ-026: After a frame error the FSM SHALL NOT re-arm until synchronized rx has been 1 for at least one cycle (prevents break-condition retriggering).

Reset
- REQ-027: While rst_n = 0:
  - data_out = 0, valid = 0, frame_err = 0, parity_err = 0, overrun = 0;
  - FSM = IDLE, counters = 0, synchronizer flops = 1.
- REQ-028: Reset mid-frame SHALL abort the frame with no valid pulse; reception SHALL resume at the next falling edge after release.

Configuration
- REQ-029: Macro UART_RX_PARITY_EN defined: PARITY state, parity check and parity_err are compiled in, honoring PARITY_MODE.
- REQ-030: Macro undefined: the PARITY state is absent, PARITY_MODE is ignored, and parity_err is tied to 0.

Structure
- REQ-031: Shared package uart_pkg SHALL hold the FSM state enum, the PARITY_MODE encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and the counter-width function clog2-based constant.
- REQ-032: One sub-module, uart_bit_timer (bit counter with half/full-bit tick outputs), SHALL be instantiated; everything else SHALL be flat.

Verification
All scenarios use CLK_FREQ = 100_000_000 and BAUD_RATE = 1_000_000 (CLKS_PER_BIT = 100).
- REQ-033: 8N1, send 0xA5, ready = 1 -> valid for 1 cycle; data_out = 0xA5; frame_err = 0.
- REQ-034: 7E1 with macro defined, send 0x41 with a wrong parity bit -> valid = 1, data_out = 0x41, parity_err = 1.
- REQ-035: rx low pulse of 30 cycles -> no valid; FSM back in IDLE by cycle 52.
- REQ-036: ready = 0, send 0x11 then 0x22 -> data_out stays 0x11; overrun pulses once at the end of the second frame.
- REQ-037: 8N2, second stop bit driven 0 on byte 0x3C -> data_out = 0x3C, frame_err = 1; the next frame 0x5A is received cleanly after rx returns high.
- REQ-038: rst_n asserted at DATA bit 4 of 0xFF -> all outputs 0, no valid; the following 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART receiver:
//   - rx_state_e     : receiver FSM state encoding
//   - PAR_NONE/ODD/EVEN : PARITY_MODE encodings
//   - bit_cnt_width(): width of the bit-timing counter for a given divisor
// The PARITY state is only ever entered when the receiver is built with
// UART_RX_PARITY_EN defined.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Counter must hold 0 .. clks_per_bit-1; keep at least one bit.
  function automatic int bit_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Single bit-timing counter shared by all non-idle receiver states.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (counter -> 0)
//   run_i        count enable; when low the counter is held at 0
//   clr_i        synchronous clear, takes priority over counting
//   half_tick_o  counter is at CLKS_PER_BIT/2 - 1 (middle of the start bit)
//   full_tick_o  counter is at CLKS_PER_BIT - 1 (one full bit elapsed)
// The counter wraps to 0 by itself after a full tick so consecutive bits are
// timed back to back without help from the FSM.
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int CNT_W        = bit_cnt_width(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign half_tick_o = run_i && (count_q == HALF_LAST);
  assign full_tick_o = run_i && (count_q == FULL_LAST);

  always_comb begin
    count_d = count_q;
    if (!run_i || clr_i || full_tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver with a valid/ready output hold register.
// Parameters:
//   CLK_FREQ    system clock in Hz
//   BAUD_RATE   line bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
//   DATA_BITS   payload bits per frame (5..9), LSB first
//   PARITY_MODE PAR_NONE / PAR_ODD / PAR_EVEN
//   STOP_BITS   1 or 2
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx          asynchronous serial line, idle high
//   data_out    received payload, stable while valid is high
//   valid       payload available, held until accepted
//   ready       consumer accepts on a rising edge with valid && ready
//   frame_err   qualifies data_out: a stop bit was sampled low
//   parity_err  qualifies data_out: parity check failed
//   overrun     one-cycle pulse: a completed frame was dropped
// Build option:
//   UART_RX_PARITY_EN  when defined, the PARITY state and parity check are
//                      compiled in and PARITY_MODE is honoured; otherwise
//                      PARITY_MODE is ignored and parity_err is constant 0.
// -----------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int IDX_W        = 4;  // indexes up to 8 (DATA_BITS <= 9)

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = (PARITY_MODE != PAR_NONE);
`else
  // Parity support not built: constant 0, so the PARITY state is never
  // entered and PARITY_MODE has no effect on the hardware.
  localparam bit PARITY_ON = 1'b0 && (PARITY_MODE != PAR_NONE);
`endif

  // ---------------------------------------------------------------------------
  // Input synchronizer; flops reset to the idle (high) line level so a reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  rx_state_e             state_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  stop_idx_q;
  logic                  stop_err_q;     // an earlier stop sample of this frame was low
  logic                  rearm_block_q;  // set after a framing error until the line idles
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                  par_err_q;      // parity result of the frame in flight
  logic                  parity_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Bit timer: runs in every state except IDLE; cleared when the start bit
  // has been confirmed so DATA samples land in the middle of each bit.
  // ---------------------------------------------------------------------------
  logic tmr_run;
  logic tmr_clr;
  logic half_tick;
  logic full_tick;

  assign tmr_run = (state_q != IDLE);
  assign tmr_clr = (state_q == START) && half_tick;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (tmr_run),
    .clr_i       (tmr_clr),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick)
  );

  // ---------------------------------------------------------------------------
  // Frame completion and output-register load decision
  // ---------------------------------------------------------------------------
  logic frame_done;
  logic frame_err_d;
  logic load_frame;

  assign frame_done  = (state_q == STOP) && full_tick &&
                       (stop_idx_q == 1'(STOP_BITS - 1));
  assign frame_err_d = stop_err_q | ~rx_sync_q;
  // A held, unaccepted word wins over a new frame; otherwise load, including
  // the case where the held word is accepted in this very cycle.
  assign load_frame  = frame_done && (!valid_q || ready);

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY_MODE == PAR_ODD) ? ~x : x;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      stop_err_q    <= 1'b0;
      rearm_block_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;

      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      if (load_frame) begin
        data_q      <= shift_q;
        frame_err_q <= frame_err_d;
        valid_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= par_err_q;
`endif
      end

      if (frame_done && valid_q && !ready) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (rx_sync_q) begin
            rearm_block_q <= 1'b0;
          end
          if (!rx_sync_q && !rearm_block_q) begin
            state_q <= START;
          end
        end

        START: begin
          // Mid start bit: a line back high was only a glitch.
          if (half_tick) begin
            bit_idx_q <= '0;
            state_q   <= rx_sync_q ? IDLE : DATA;
          end
        end

        DATA: begin
          if (full_tick) begin
            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              bit_idx_q  <= '0;
              stop_idx_q <= 1'b0;
              stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_err_q  <= 1'b0;
`endif
              state_q    <= PARITY_ON ? PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full_tick) begin
            par_err_q <= parity_bad(shift_q, rx_sync_q);
            state_q   <= STOP;
          end
        end
`endif

        STOP: begin
          if (full_tick) begin
            if (!rx_sync_q) begin
              stop_err_q <= 1'b1;
            end
            if (frame_done) begin
              // A low stop bit may be a break; wait for the line to idle.
              rearm_block_q <= frame_err_d;
              state_q       <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Bench with three receivers sharing clock and reset:
//   inst 0: 8N1, inst 1: 8N2, inst 2: 7 data bits, even parity, 1 stop
//   (inst 2 frames carry a parity bit only when UART_RX_PARITY_EN is defined).
// Stimulus pushes expected words into a queue; a negedge monitor pops on every
// valid && ready handshake and compares.
module tb_uart_rx_param;

  localparam int CPB = 100;  // 100 MHz / 1 Mbaud
  localparam int NI  = 3;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_l    [NI];
  logic ready_l [NI];
  logic valid_l [NI];
  logic ferr_l  [NI];
  logic perr_l  [NI];
  logic ovr_l   [NI];
  logic [7:0] dout_a;
  logic [7:0] dout_b;
  logic [6:0] dout_c;
  logic [8:0] dout_l [NI];

  assign dout_l[0] = {1'b0, dout_a};
  assign dout_l[1] = {1'b0, dout_b};
  assign dout_l[2] = {2'b00, dout_c};

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_seen [NI];
  int   exp_ovr  [NI];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .data_out(dout_a), .valid(valid_l[0]),
    .ready(ready_l[0]), .frame_err(ferr_l[0]), .parity_err(perr_l[0]), .overrun(ovr_l[0]));

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .data_out(dout_b), .valid(valid_l[1]),
    .ready(ready_l[1]), .frame_err(ferr_l[1]), .parity_err(perr_l[1]), .overrun(ovr_l[1]));

  uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                  .PARITY_MODE(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .data_out(dout_c), .valid(valid_l[2]),
    .ready(ready_l[2]), .frame_err(ferr_l[2]), .parity_err(perr_l[2]), .overrun(ovr_l[2]));

  // ---------------- frame format of each instance ----------------
  function automatic int n_data(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int n_stop(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic bit has_par(input int i);
`ifdef UART_RX_PARITY_EN
    return (i == 2);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int inst, input logic v);
    rx_l[inst] = v;
    tick(CPB);
  endtask

  // Sends one frame; the expected word is queued when the receiver should load it.
  task automatic send_frame(input int inst, input logic [8:0] d, input logic [1:0] stop_v,
                            input bit bad_par, input bit expect_load);
    logic [8:0] dm;
    logic       pbit;
    exp_t       e;
    dm = '0;
    for (int b = 0; b < n_data(inst); b++) dm[b] = d[b];
    pbit = (^dm) ^ bad_par;  // even parity: correct bit makes the total count of ones even
    e.inst = inst;
    e.data = dm;
    e.ferr = (stop_v[0] == 1'b0) || ((n_stop(inst) == 2) && (stop_v[1] == 1'b0));
    e.perr = has_par(inst) && (($countones({dm, pbit}) % 2) == 1);
    if (expect_load) exp_q.push_back(e);
    drive_bit(inst, 1'b0);
    for (int b = 0; b < n_data(inst); b++) drive_bit(inst, dm[b]);
    if (has_par(inst)) drive_bit(inst, pbit);
    for (int s = 0; s < n_stop(inst); s++) drive_bit(inst, stop_v[s]);
    rx_l[inst] = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected words never delivered, required 0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (valid_l[i] !== 1'b0 || dout_l[i] !== 9'h000 || ferr_l[i] !== 1'b0 ||
          perr_l[i] !== 1'b0 || ovr_l[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s inst=%0d: valid=%b data=0x%0h fe=%b pe=%b ovr=%b, required all 0",
                 name, i, valid_l[i], dout_l[i], ferr_l[i], perr_l[i], ovr_l[i]);
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (ovr_l[i]) ovr_seen[i]++;
        if (valid_l[i] && ready_l[i]) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_valid inst=%0d: data=0x%0h fe=%b pe=%b, required no valid",
                     i, dout_l[i], ferr_l[i], perr_l[i]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.inst != i || dout_l[i] !== mon_e.data || ferr_l[i] !== mon_e.ferr ||
                perr_l[i] !== mon_e.perr) begin
              miscompares++;
              $display("FAIL rx_word inst=%0d: data=0x%0h fe=%b pe=%b, required inst=%0d data=0x%0h fe=%b pe=%b",
                       i, dout_l[i], ferr_l[i], perr_l[i], mon_e.inst, mon_e.data, mon_e.ferr, mon_e.perr);
            end else begin
              $display("rx inst=%0d data=0x%0h fe=%b pe=%b ok", i, dout_l[i], ferr_l[i], perr_l[i]);
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int         inst;
    logic [8:0] d;
    logic [1:0] sv;
    bit         bp;

    for (int i = 0; i < NI; i++) begin
      rx_l[i]    = 1'b1;
      ready_l[i] = 1'b1;
      ovr_seen[i] = 0;
      exp_ovr[i]  = 0;
    end
    rst_n = 1'b0;
    tick(5);
    check_reset("reset_state");
    rst_n = 1'b1;
    tick(20);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 2'b11, 1'b0, 1'b1);
    drain("basic_a5", 200);
    tick(10);

    // 30-cycle glitch must be rejected; the next frame proves the FSM re-armed
    rx_l[0] = 1'b0;
    tick(30);
    rx_l[0] = 1'b1;
    tick(30);
    send_frame(0, 9'h096, 2'b11, 1'b0, 1'b1);
    drain("after_glitch", 200);
    tick(10);

    // Overrun: hold ready low across two frames
    ready_l[0] = 1'b0;
    send_frame(0, 9'h011, 2'b11, 1'b0, 1'b1);
    tick(5);
    send_frame(0, 9'h022, 2'b11, 1'b0, 1'b0);
    exp_ovr[0]++;
    tick(20);
    vectors++;
    if (valid_l[0] !== 1'b1 || dout_l[0] !== 9'h011) begin
      miscompares++;
      $display("FAIL held_word: valid=%b data=0x%0h, required valid=1 data=0x11", valid_l[0], dout_l[0]);
    end
    ready_l[0] = 1'b1;
    drain("overrun_release", 50);
    tick(10);

    // 8N2 with second stop bit low, then a clean frame
    send_frame(1, 9'h03C, 2'b01, 1'b0, 1'b1);
    drain("stop2_err", 200);
    tick(10);
    send_frame(1, 9'h05A, 2'b11, 1'b0, 1'b1);
    drain("after_frame_err", 200);
    tick(10);

    // 7E1: wrong then correct parity bit
    send_frame(2, 9'h041, 2'b11, 1'b1, 1'b1);
    drain("bad_parity", 200);
    tick(10);
    send_frame(2, 9'h041, 2'b11, 1'b0, 1'b1);
    drain("good_parity", 200);
    tick(10);

    // Reset in DATA bit 4 of 0xFF, then a clean 0x0F
    rx_l[0] = 1'b0;
    tick(CPB);
    rx_l[0] = 1'b1;
    tick(4 * CPB + 50);
    rst_n = 1'b0;
    tick(3);
    check_reset("reset_mid_frame");
    tick(5 * CPB);
    rst_n = 1'b1;
    tick(20);
    send_frame(0, 9'h00F, 2'b11, 1'b0, 1'b1);
    drain("after_reset", 200);
    tick(10);

    // Randomised frames on all instances
    for (int k = 0; k < 24; k++) begin
      inst = int'($urandom_range(0, NI - 1));
      d    = 9'($urandom);
      sv   = 2'b11;
      if ($urandom_range(0, 5) == 0) sv[$urandom_range(0, n_stop(inst) - 1)] = 1'b0;
      bp   = ($urandom_range(0, 3) == 0);
      send_frame(inst, d, sv, bp, 1'b1);
      drain("random", 300);
      tick(int'($urandom_range(3, 40)));
    end

    tick(20);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (ovr_seen[i] != exp_ovr[i]) begin
        miscompares++;
        $display("FAIL overrun_count inst=%0d: seen %0d pulses, required %0d", i, ovr_seen[i], exp_ovr[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
